// File: rtl/ps2_host_tx_module.sv
// ps2_host_tx_module: PS/2 host-to-device byte transmitter driving open-drain pull-low enables
module ps2_host_tx_module #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       PS2_CLK_Pin_In,
  input  logic       PS2_Data_Pin_In,
  input  logic [7:0] TX_Data,
  input  logic       TX_Start_Sig,
  output logic       PS2_CLK_Oe,
  output logic       PS2_Data_Oe,
  output logic       TX_Busy,
  output logic       TX_Done_Sig,
  output logic       TX_Err_Sig
);
  localparam int MAXC = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  typedef enum logic [2:0] {S_IDLE, S_INHIBIT, S_RTS, S_SEND, S_ACK, S_WAIT_REL, S_DONE, S_ERR} state_t;
  state_t r_state, w_next;
  logic r_clk_s1, r_clk_s2, r_clk_prev, r_dat_s1, r_dat_s2, r_bit;
  logic [8:0] r_shift;
  logic [3:0] r_edge;
  logic [CW-1:0] r_cnt;
  logic w_fall, w_inhibit_end, w_timeout, w_tracking;
  assign w_fall = r_clk_prev & ~r_clk_s2;
  assign w_inhibit_end = r_cnt == CW'(INHIBIT_CYCLES - 1);
  assign w_timeout = r_cnt == CW'(TIMEOUT_CYCLES - 1);
  assign w_tracking = r_state inside {S_SEND, S_ACK, S_WAIT_REL};
  assign PS2_CLK_Oe = r_state inside {S_INHIBIT, S_RTS};
  assign PS2_Data_Oe = (r_state == S_RTS) | ((r_state == S_SEND) & ~r_bit);
  assign TX_Busy = r_state inside {S_INHIBIT, S_RTS, S_SEND, S_ACK, S_WAIT_REL};
  assign TX_Done_Sig = r_state == S_DONE;
  assign TX_Err_Sig = r_state == S_ERR;
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      {r_clk_s1, r_clk_s2, r_clk_prev, r_dat_s1, r_dat_s2} <= '0;
    end else begin
      r_clk_s1 <= PS2_CLK_Pin_In;
      r_clk_s2 <= r_clk_s1;
      r_clk_prev <= r_clk_s2;
      r_dat_s1 <= PS2_Data_Pin_In;
      r_dat_s2 <= r_dat_s1;
    end
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= S_IDLE;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     w_next = TX_Start_Sig ? S_INHIBIT : S_IDLE;
      S_INHIBIT:  w_next = w_inhibit_end ? S_RTS : S_INHIBIT;
      S_RTS:      w_next = S_SEND;
      S_SEND:     w_next = w_fall ? (r_edge == 4'd9 ? S_ACK : S_SEND) : (w_timeout ? S_ERR : S_SEND);
      S_ACK:      w_next = w_fall ? (r_dat_s2 ? S_ERR : S_WAIT_REL) : (w_timeout ? S_ERR : S_ACK);
      S_WAIT_REL: w_next = (r_clk_s2 && r_dat_s2) ? S_DONE : ((w_timeout && !w_fall) ? S_ERR : S_WAIT_REL);
      default:    w_next = S_IDLE;
    endcase
  end
  // shift register refills with 1s so the tenth edge naturally presents the stop bit
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_shift <= '0;
      r_edge <= '0;
      r_cnt <= '0;
      r_bit <= 1'b0;
    end else if (r_state == S_IDLE && TX_Start_Sig) begin
      r_shift <= {~^TX_Data, TX_Data};
      r_cnt <= '0;
    end else if (r_state == S_INHIBIT) begin
      r_cnt <= r_cnt + CW'(1);
    end else if (r_state == S_RTS) begin
      r_cnt <= '0;
      r_edge <= '0;
      r_bit <= 1'b0;
    end else if (w_tracking) begin
      r_cnt <= w_fall ? '0 : r_cnt + CW'(1);
      if (w_fall && r_edge != 4'd11) r_edge <= r_edge + 4'd1;
      if (w_fall && r_state == S_SEND) begin
        r_bit <= r_shift[0];
        r_shift <= {1'b1, r_shift[8:1]};
      end
    end
  end
endmodule

// File: tb/tb_ps2_host_tx_module.sv
// tb_ps2_host_tx_module: PS/2 device model clocks frames out of the host transmitter and checks them
module tb_ps2_host_tx_module;
  localparam int INH = 20, TO = 200, HP = 40;
  typedef struct {
    logic [7:0]  data;
    bit          ack;
    logic [10:0] exp_bits;
    bit          exp_done;
  } vec_t;
  logic clk = 1'b0, rst = 1'b1, tx_start = 1'b0, dev_clk = 1'b1, dev_dat = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic clk_oe, data_oe, busy, done, err, ps2_clk, ps2_dat;
  int tests = 0, fails = 0;
  int n_done = 0, n_err = 0, n_oe_hi = 0, busy_bad = 0, cyc = 0, t_rel = 0, t_err = 0;
  logic prev_busy = 1'b0, prev_clk_oe = 1'b0;
  vec_t vecs[4];
  assign ps2_clk = dev_clk & ~clk_oe;
  assign ps2_dat = dev_dat & ~data_oe;
  ps2_host_tx_module #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
    .CLK(clk), .RST(rst), .PS2_CLK_Pin_In(ps2_clk), .PS2_Data_Pin_In(ps2_dat),
    .TX_Data(tx_data), .TX_Start_Sig(tx_start), .PS2_CLK_Oe(clk_oe), .PS2_Data_Oe(data_oe),
    .TX_Busy(busy), .TX_Done_Sig(done), .TX_Err_Sig(err)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    cyc++;
    if (done) begin
      n_done++;
      if (busy || !prev_busy) busy_bad++;
    end
    if (err) begin
      n_err++;
      t_err = cyc;
    end
    if (clk_oe) n_oe_hi++;
    if (prev_clk_oe && !clk_oe) t_rel = cyc;
    prev_busy = busy;
    prev_clk_oe = clk_oe;
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask
  // frame as seen on the wire: start 0, data LSB first, odd parity, stop 1
  function automatic logic [10:0] frame_of(input logic [7:0] d);
    logic p;
    p = ($countones(d) % 2) == 0;
    return {1'b1, p, d, 1'b0};
  endfunction
  task automatic wait_rts(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 1000 && !ok; i++) begin
      @(negedge clk);
      if (ps2_clk && !ps2_dat) ok = 1'b1;
    end
  endtask
  task automatic dev_run(input bit ack, output logic [10:0] bits, output bit ok);
    bits = '0;
    wait_rts(ok);
    if (!ok) return;
    repeat (HP) @(negedge clk);
    for (int k = 0; k < 11; k++) begin
      bits[k] = ps2_dat;
      dev_clk = 1'b0;
      if (k == 10 && ack) dev_dat = 1'b0;
      repeat (HP) @(negedge clk);
      dev_clk = 1'b1;
      dev_dat = 1'b1;
      repeat (HP) @(negedge clk);
    end
  endtask
  task automatic pulse_start(input logic [7:0] d);
    @(negedge clk);
    tx_data = d;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
  endtask
  task automatic run_vec(input string nm, input logic [7:0] d, input bit ack,
                         input logic [10:0] exp_bits, input bit exp_done, input bit spurious);
    int b_done, b_err, b_oe, b_bad;
    logic [10:0] bits;
    bit ok;
    b_done = n_done; b_err = n_err; b_oe = n_oe_hi; b_bad = busy_bad;
    pulse_start(d);
    fork
      dev_run(ack, bits, ok);
      if (spurious) begin
        repeat (300) @(negedge clk);
        tx_data = ~d;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
      end
    join
    repeat (10) @(negedge clk);
    chk({nm, " rts_seen"}, 32'(ok), 32'd1);
    chk({nm, " frame"}, 32'(bits), 32'(exp_bits));
    chk({nm, " clk_oe_cycles"}, n_oe_hi - b_oe, INH + 1);
    chk({nm, " done_pulses"}, n_done - b_done, 32'(exp_done));
    chk({nm, " err_pulses"}, n_err - b_err, 32'(!exp_done));
    chk({nm, " busy_at_done"}, busy_bad - b_bad, 0);
    chk({nm, " idle_outputs"}, {clk_oe, data_oe, busy, done, err}, 5'b0);
  endtask
  initial begin
    logic [10:0] bits;
    logic [7:0] d;
    bit ok, a;
    int b_done, b_err;
    vecs[0] = '{8'hFF, 1'b1, 11'b1_1_11111111_0, 1'b1};
    vecs[1] = '{8'hF4, 1'b1, 11'b1_0_11110100_0, 1'b1};
    vecs[2] = '{8'hED, 1'b1, 11'b1_1_11101101_0, 1'b1};
    vecs[3] = '{8'h00, 1'b0, 11'b1_1_00000000_0, 1'b0};
    #1 chk("reset_outputs", {clk_oe, data_oe, busy, done, err}, 5'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    foreach (vecs[i]) run_vec($sformatf("vec%0d", i), vecs[i].data, vecs[i].ack, vecs[i].exp_bits, vecs[i].exp_done, 1'b0);
    for (int i = 0; i < 6; i++) begin
      d = 8'($urandom);
      a = ($urandom_range(0, 3) != 0);
      run_vec($sformatf("rand%0d_%02h", i, d), d, a, frame_of(d), a, 1'b0);
    end
    run_vec("midframe_start", 8'h3C, 1'b1, frame_of(8'h3C), 1'b1, 1'b1);
    repeat (50) @(negedge clk);
    chk("midframe_no_restart", 32'(busy), 32'd0);
    // device never clocks: host must give up exactly TO cycles after releasing the clock
    b_done = n_done; b_err = n_err;
    pulse_start(8'hA5);
    for (int i = 0; i < 1000 && n_err == b_err; i++) @(negedge clk);
    chk("timeout_err_pulses", n_err - b_err, 1);
    chk("timeout_latency", t_err - t_rel, TO);
    chk("timeout_no_done", n_done - b_done, 0);
    chk("timeout_released", {clk_oe, data_oe}, 2'b00);
    repeat (5) @(negedge clk);
    chk("timeout_idle", 32'(busy), 32'd0);
    // reset during the fifth data clock while a zero bit is being driven
    b_done = n_done; b_err = n_err;
    pulse_start(8'h00);
    fork
      dev_run(1'b1, bits, ok);
      begin
        wait_rts(ok);
        repeat (HP + 4 * 2 * HP + 10) @(negedge clk);
        chk("pre_reset_data_oe", 32'(data_oe), 32'd1);
        rst = 1'b1;
        #1 chk("reset_mid_release", {clk_oe, data_oe, busy}, 3'b000);
        repeat (3) @(negedge clk);
        rst = 1'b0;
      end
    join
    repeat (10) @(negedge clk);
    chk("reset_mid_no_done", n_done - b_done, 0);
    chk("reset_mid_no_err", n_err - b_err, 0);
    run_vec("after_reset", 8'h96, 1'b1, frame_of(8'h96), 1'b1, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ps2_host_tx_module.md
Name: ps2_host_tx_module

Overview:
Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xFF reset, 0xED LED set, 0xF4 enable) to a keyboard/mouse over the shared PS2 clock/data lines. It is the transmit-side counterpart to the PS/2 receive path (detect + decode). The block drives both lines open-drain via active-high pull-low enables and follows the device-generated clock. Top level ties each pin to 1'bz/0 from the enables and feeds the same pins back into the receive path.

Parameters:
INHIBIT_CYCLES, 5000, CLK cycles the PS2 clock is held low before the request-to-send (100 us at 50 MHz)
TIMEOUT_CYCLES, 100000, max CLK cycles between consecutive device falling edges, and before the first one (2 ms at 50 MHz)

Ports:
CLK  input  1  system clock
RST  input  1  asynchronous, active-high reset
PS2_CLK_Pin_In  input  1  raw PS2 clock pin (asynchronous)
PS2_Data_Pin_In  input  1  raw PS2 data pin (asynchronous)
TX_Data  input  8  byte to send; sampled only when a start is accepted
TX_Start_Sig  input  1  one-cycle request; accepted only in IDLE
PS2_CLK_Oe  output  1  1 = pull PS2 clock low, 0 = release
PS2_Data_Oe  output  1  1 = pull PS2 data low, 0 = release
TX_Busy  output  1  high from accepted start until return to IDLE
TX_Done_Sig  output  1  one-cycle pulse: byte sent and device ACK = 0
TX_Err_Sig  output  1  one-cycle pulse: missing ACK or timeout

Behaviour:
- Reset (async, RST=1): all outputs 0, so both lines are released; FSM goes to IDLE; counters and shift register are cleared. Reset mid-transfer releases the lines immediately, with no Done/Err pulse.
- Input conditioning:
  - Both pins pass through 2-FF synchronisers.
  - A falling edge is detected as prev=1, cur=0 on the synchronised clock, giving a one-cycle fall strobe 3 cycles after the pin falls.
- Frame: start 0, D0..D7 LSB first, odd parity (~^TX_Data), stop 1, then ACK driven by the device. Data_Oe = ~bit_value.
- IDLE:
  - TX_Busy=0, both Oe=0.
  - On TX_Start_Sig=1: latch {parity, TX_Data} into the shift register and go to INHIBIT.
  - TX_Start_Sig in any other state is ignored.
- INHIBIT:
  - TX_Busy=1, CLK_Oe=1, Data_Oe=0, for exactly INHIBIT_CYCLES cycles.
  - Then go to RTS.
- RTS:
  - One cycle with CLK_Oe=1 and Data_Oe=1 (start bit).
  - Next cycle CLK_Oe=0, Data_Oe=1; go to SEND with the edge count at 0.
  - The timeout counter is cleared.
- SEND:
  - Action on each fall strobe, by edge count n (1..10):
    - n=1..8: present D(n-1).
    - n=9: present parity.
    - n=10: Data_Oe=0 (stop bit, line released).
  - Data_Oe updates on the cycle after the strobe.
  - After n=10, go to ACK.
- ACK: on the next fall strobe (11th), sample the synchronised data line.
  - If 0: go to WAIT_REL.
  - If 1: go to ERR.
- WAIT_REL: wait for synchronised clock=1 and data=1, then go to DONE.
- DONE: pulse TX_Done_Sig for 1 cycle; go to IDLE, with TX_Busy=0 on the same cycle as the pulse.
- ERR: both Oe=0, TX_Err_Sig pulse for 1 cycle, TX_Busy=0; go to IDLE.
- Timeout:
  - In SEND, ACK and WAIT_REL, a counter increments every cycle and clears on each fall strobe.
  - When it reaches TIMEOUT_CYCLES, go to ERR.
- Glitches: a fall strobe arriving in INHIBIT or RTS is ignored.
- The edge counter is 4 bits wide and never wraps; its range is 0..11.

Test Plan:
- Setup: INHIBIT_CYCLES=20, TIMEOUT_CYCLES=200; device model clocks at 40-cycle half-period, samples data on rising edges, and ACKs low on the 11th clock.
- Send 0xFF -> CLK_Oe high 21 cycles (20 + RTS); sampled bits 0,1,1,1,1,1,1,1,1,parity 1,stop 1; TX_Done_Sig pulses once; TX_Busy falls the same cycle.
- Send 0xF4 -> bits 0,0,0,1,0,1,1,1,1,parity 0,stop 1; Done pulse. Send 0xED -> parity 1; Done pulse.
- Device leaves data high at the 11th clock -> TX_Err_Sig pulses once, no Done, both Oe=0, back to IDLE.
- Device never clocks after RTS -> TX_Err_Sig exactly 200 cycles after CLK_Oe release; lines released.
- TX_Start_Sig pulsed mid-frame with a different byte -> ignored, original byte is sent intact. Separately, assert RST at edge 5 -> both Oe=0 combinationally, no pulses; a new start after reset sends a clean frame.
